// File: rtl/frame_scheduler.sv
// frame_scheduler
// Buffers the incoming sample stream in a circular RAM. Each time a full frame is
// buffered, the frame is replayed to the window stage as one contiguous
// FRAME_LEN-sample burst. The read base then advances by HOP samples, and
// GAP_CYCLES idle cycles follow so the window pipeline can drain.
module frame_scheduler #(
    parameter int unsigned SAMPLE_W   = 20,
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned HOP        = 512,
    parameter int unsigned BUF_AW     = 11,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [SAMPLE_W-1:0]          s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [SAMPLE_W-1:0]          win_data,
    output logic                         win_valid,
    output logic                         win_frame_start,
    output logic [$clog2(FRAME_LEN)-1:0] win_idx,
    output logic [15:0]                  frame_cnt,
    output logic                         busy
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned CNT_W = BUF_AW + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_HOP   = CNT_W'(HOP);
    localparam logic [BUF_AW-1:0] PTR_HOP   = BUF_AW'(HOP);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [BUF_AW-1:0]   wr_ptr;
    logic [BUF_AW-1:0]   rd_base;
    logic [BUF_AW-1:0]   rd_addr;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nxt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_nxt;
    logic                accept;
    logic                retire;
    logic                rd_en;
    logic                ready_q;
    logic [SAMPLE_W-1:0] rd_q;
    logic [SAMPLE_W-1:0] mem [DEPTH];

    // ready_q is kept equal to (count < DEPTH); it is a register so that it reads 0 during reset
    assign s_ready = ready_q;
    assign accept  = s_valid && ready_q;
    assign rd_addr = rd_base + BUF_AW'(idx);
    assign busy    = (state != S_IDLE);

    // The RAM has no reset, so the read register is masked to give a clean 0 outside bursts
    assign win_data = win_valid ? rd_q : '0;

    // Frame sequencing: wait for a full frame, burst it out, then idle for the drain gap
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        rd_en     = 1'b0;
        retire    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable && (count >= CNT_FRAME)) begin
                    state_nxt = S_RUN;
                    idx_nxt   = '0;
                end
            end
            S_RUN: begin
                rd_en   = 1'b1;
                idx_nxt = idx + 1'b1;
                if (idx == IDX_LAST) begin
                    // the last read has just been issued, so the oldest HOP samples may be released
                    retire    = 1'b1;
                    state_nxt = S_GAP;
                    gap_nxt   = GAP_LOAD;
                    idx_nxt   = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_nxt = gap_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Occupancy: an accept and a retire in the same cycle both take effect
    always_comb begin
        count_nxt = count;
        if (accept) begin
            count_nxt = count_nxt + 1'b1;
        end
        if (retire) begin
            count_nxt = count_nxt - CNT_HOP;
        end
    end

    // FSM state, burst index and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Buffer bookkeeping: occupancy, write pointer, read base and completed-frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            ready_q   <= 1'b0;
            wr_ptr    <= '0;
            rd_base   <= '0;
            frame_cnt <= '0;
        end else begin
            count   <= count_nxt;
            ready_q <= (count_nxt < CNT_DEPTH);
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_base   <= rd_base + PTR_HOP;
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Window-side qualifiers, delayed one cycle to line up with the RAM read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid       <= 1'b0;
            win_frame_start <= 1'b0;
            win_idx         <= '0;
        end else begin
            win_valid       <= rd_en;
            win_frame_start <= rd_en && (idx == '0);
            win_idx         <= idx;
        end
    end

    // Sample RAM: one write port and one registered read port; frame samples are never overwritten
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= s_data;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
// Directed bench for frame_scheduler. dut_a uses a half-frame hop and dut_b uses
// non-overlapping frames. The two instances share their input stimulus, and only
// one of them is out of reset at any time. Each sample value equals its stream
// index since reset, so every window sample can be predicted from the frame
// number and the hop.
`timescale 1ns/1ps
module tb_frame_scheduler;

    localparam int FRAME_LEN = 1024;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        enable;
    logic        s_valid;
    logic [19:0] s_data;
    logic        sel;

    logic        s_ready_a, win_valid_a, win_start_a, busy_a;
    logic [19:0] win_data_a;
    logic [9:0]  win_idx_a;
    logic [15:0] frame_cnt_a;
    logic        s_ready_b, win_valid_b, win_start_b, busy_b;
    logic [19:0] win_data_b;
    logic [9:0]  win_idx_b;
    logic [15:0] frame_cnt_b;

    logic        m_rst, m_ready, m_valid, m_start, m_busy;
    logic [19:0] m_data;
    logic [9:0]  m_idx;
    logic [15:0] m_frame_cnt;
    logic [11:0] m_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_idx = 0;
    int mon_frames = 0;
    int gap = 0;
    int gap_q[$];

    always #5 clk = ~clk;

    frame_scheduler #(
        .SAMPLE_W(20), .FRAME_LEN(1024), .HOP(512), .BUF_AW(11), .GAP_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst_a), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready_a), .win_data(win_data_a), .win_valid(win_valid_a),
        .win_frame_start(win_start_a), .win_idx(win_idx_a), .frame_cnt(frame_cnt_a),
        .busy(busy_a)
    );

    frame_scheduler #(
        .SAMPLE_W(20), .FRAME_LEN(1024), .HOP(1024), .BUF_AW(11), .GAP_CYCLES(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready_b), .win_data(win_data_b), .win_valid(win_valid_b),
        .win_frame_start(win_start_b), .win_idx(win_idx_b), .frame_cnt(frame_cnt_b),
        .busy(busy_b)
    );

    assign m_rst       = sel ? rst_b       : rst_a;
    assign m_ready     = sel ? s_ready_b   : s_ready_a;
    assign m_valid     = sel ? win_valid_b : win_valid_a;
    assign m_start     = sel ? win_start_b : win_start_a;
    assign m_busy      = sel ? busy_b      : busy_a;
    assign m_data      = sel ? win_data_b  : win_data_a;
    assign m_idx       = sel ? win_idx_b   : win_idx_a;
    assign m_frame_cnt = sel ? frame_cnt_b : frame_cnt_a;
    assign m_count     = sel ? dut_b.count : dut_a.count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Streams n consecutive sample values starting at 'first', one per accepted cycle
    task automatic push(input int first, input int n);
        int waited;
        for (int i = 0; i < n; i++) begin
            waited  = 0;
            s_valid = 1'b1;
            s_data  = 20'(first + i);
            while (!m_ready && waited < 5000) begin
                tick(1);
                waited++;
            end
            if (waited >= 5000) begin
                check("push_timeout", 32'(waited), 32'(0));
                s_valid = 1'b0;
                return;
            end
            tick(1);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (m_frame_cnt != 16'(n) && c < budget) begin
            tick(1);
            c++;
        end
        check("frame_cnt_wait", 32'(m_frame_cnt), 32'(n));
    endtask

    task automatic reset_a();
        s_valid = 1'b0;
        rst_a   = 1'b1;
        tick(2);
        rst_a   = 1'b0;
        tick(1);
    endtask

    // Predicts every window sample and records the idle run between consecutive bursts
    task automatic monitor();
        int hop;
        forever begin
            @(negedge clk);
            hop = sel ? 1024 : 512;
            if (m_rst) begin
                exp_idx    = 0;
                mon_frames = 0;
                gap        = 0;
                gap_q.delete();
            end else if (m_valid) begin
                if (exp_idx == 0 && mon_frames > 0) gap_q.push_back(gap);
                check("win_idx", 32'(m_idx), 32'(exp_idx));
                check("win_data", 32'(m_data), 32'(mon_frames * hop + exp_idx));
                check("win_frame_start", 32'(m_start), 32'(exp_idx == 0));
                exp_idx++;
                if (exp_idx == FRAME_LEN) begin
                    exp_idx = 0;
                    mon_frames++;
                    gap = 0;
                end
            end else begin
                if (exp_idx != 0) check("burst_contig", 32'(m_valid), 32'(1));
                gap++;
            end
        end
    endtask

    initial begin
        int c;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        sel     = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        fork
            monitor();
        join_none

        // 1: reset values, then a single frame of 1024 samples
        tick(2);
        check("rst_s_ready", 32'(m_ready), 32'(0));
        check("rst_win_valid", 32'(m_valid), 32'(0));
        check("rst_busy", 32'(m_busy), 32'(0));
        check("rst_frame_cnt", 32'(m_frame_cnt), 32'(0));
        check("rst_win_start", 32'(m_start), 32'(0));
        check("rst_win_data", 32'(m_data), 32'(0));
        rst_a = 1'b0;
        tick(1);
        check("t1_s_ready", 32'(m_ready), 32'(1));
        check("t1_count0", 32'(m_count), 32'(0));
        enable = 1'b1;
        push(0, 1024);
        wait_frames(1, 1200);
        check("t1_count", 32'(m_count), 32'(512));
        tick(10);
        check("t1_frames_seen", 32'(mon_frames), 32'(1));
        check("t1_busy", 32'(m_busy), 32'(0));
        check("t1_frame_cnt", 32'(m_frame_cnt), 32'(1));

        // 2: 2048 samples give three overlapping frames separated by 5 idle cycles
        reset_a();
        push(0, 2048);
        wait_frames(3, 3000);
        check("t2_count", 32'(m_count), 32'(512));
        tick(10);
        check("t2_frames_seen", 32'(mon_frames), 32'(3));
        check("t2_gap_num", 32'(gap_q.size()), 32'(2));
        check("t2_gap0", 32'(gap_q[0]), 32'(5));
        check("t2_gap1", 32'(gap_q[1]), 32'(5));

        // 3: disabled scheduler fills the buffer, then drains four frames
        enable = 1'b0;
        reset_a();
        push(0, 2048);
        check("t3_full_ready", 32'(m_ready), 32'(0));
        check("t3_full_count", 32'(m_count), 32'(2048));
        s_valid = 1'b1;
        s_data  = 20'd2048;
        tick(3);
        check("t3_no_accept", 32'(m_count), 32'(2048));
        check("t3_idle_busy", 32'(m_busy), 32'(0));
        check("t3_no_frames", 32'(mon_frames), 32'(0));
        enable = 1'b1;
        wait_frames(1, 1200);
        check("t3_ready_back", 32'(m_ready), 32'(1));
        check("t3_count_retire", 32'(m_count), 32'(1536));
        push(2048, 952);
        wait_frames(4, 4000);
        check("t3_count", 32'(m_count), 32'(952));
        tick(10);
        check("t3_frames_seen", 32'(mon_frames), 32'(4));

        // 4: accept on the retire edge with 2047 samples buffered
        enable = 1'b0;
        reset_a();
        push(0, 2047);
        check("t4_count_pre", 32'(m_count), 32'(2047));
        check("t4_ready_pre", 32'(m_ready), 32'(1));
        enable = 1'b1;
        tick(1024);
        check("t4_before_retire", 32'(m_frame_cnt), 32'(0));
        check("t4_busy_last", 32'(m_busy), 32'(1));
        s_valid = 1'b1;
        s_data  = 20'd2047;
        tick(1);
        s_valid = 1'b0;
        check("t4_retire_cnt", 32'(m_frame_cnt), 32'(1));
        check("t4_retire_count", 32'(m_count), 32'(1536));
        wait_frames(3, 2200);
        check("t4_count", 32'(m_count), 32'(512));
        tick(10);
        check("t4_frames_seen", 32'(mon_frames), 32'(3));

        // 5: asynchronous reset in the middle of the second burst
        reset_a();
        push(0, 1536);
        wait_frames(1, 1200);
        c = 0;
        while (!(m_valid && m_idx == 10'd300) && c < 1200) begin
            tick(1);
            c++;
        end
        check("t5_idx300_seen", 32'(c < 1200), 32'(1));
        #2 rst_a = 1'b1;
        #1;
        check("t5_async_valid", 32'(m_valid), 32'(0));
        check("t5_async_busy", 32'(m_busy), 32'(0));
        check("t5_async_frame_cnt", 32'(m_frame_cnt), 32'(0));
        check("t5_async_ready", 32'(m_ready), 32'(0));
        tick(1);
        rst_a = 1'b0;
        tick(1);
        check("t5_post_ready", 32'(m_ready), 32'(1));
        check("t5_post_count", 32'(m_count), 32'(0));
        push(0, 1024);
        wait_frames(1, 1200);
        check("t5_count", 32'(m_count), 32'(512));
        tick(10);
        check("t5_frames_seen", 32'(mon_frames), 32'(1));

        // 6: hop equal to frame length, 4096 samples give four disjoint frames
        rst_a = 1'b1;
        sel   = 1'b1;
        tick(1);
        rst_b = 1'b0;
        tick(1);
        check("t6_ready", 32'(m_ready), 32'(1));
        push(0, 4096);
        wait_frames(4, 2000);
        check("t6_count", 32'(m_count), 32'(0));
        tick(10);
        check("t6_frames_seen", 32'(mon_frames), 32'(4));
        check("t6_frame_cnt", 32'(m_frame_cnt), 32'(4));
        check("t6_busy", 32'(m_busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
